dff_ram_fifo_ctrl: RTL and testbench



---
 rtl/dff_ram_pkg.sv | 15 +
 rtl/dff_ram_8x72.sv | 22 ++
 rtl/fifo_skid_buf2.sv | 59 +++++
 rtl/dff_ram_fifo_ctrl.sv | 106 ++++++++++
 tb/tb_dff_ram_fifo_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dff_ram_pkg.sv
// rtl/dff_ram_pkg.sv - shared constants and RAM access type for the dff_ram FIFO slice
package dff_ram_pkg;

    localparam int RAM_DW         = 72;
    localparam int RAM_AW         = 3;
    localparam int RAM_DEPTH      = 8;
    localparam int FIFO_LEVEL_MAX = 10;

    typedef enum logic [1:0] {
        RAM_IDLE,
        RAM_RD,
        RAM_WR
    } ram_op_t;

endpackage

// File: rtl/dff_ram_8x72.sv
// rtl/dff_ram_8x72.sv - single-port 8x72 flop RAM, synchronous read, write when wr_n low
module dff_ram_8x72
    import dff_ram_pkg::*;
(
    input  logic              clk,
    input  logic              wr_n,
    input  logic [RAM_AW-1:0] address,
    input  logic [RAM_DW-1:0] wdata,
    output logic [RAM_DW-1:0] rdata
);

    logic [RAM_DW-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (!wr_n) begin
            mem[address] <= wdata;
        end else begin
            rdata <= mem[address];
        end
    end

endmodule

// File: rtl/fifo_skid_buf2.sv
// rtl/fifo_skid_buf2.sv - 2-entry output buffer that absorbs the RAM read latency
module fifo_skid_buf2 #(
    parameter int DW = 72
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          capture,
    input  logic          pop,
    input  logic [DW-1:0] cap_data,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic [1:0]    cnt
);

    logic [DW-1:0] ent0;
    logic [DW-1:0] ent1;
    logic [1:0]    cnt_q;
    logic          pop_ok;

    assign pop_ok = pop && (cnt_q != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0  <= '0;
            ent1  <= '0;
            cnt_q <= 2'd0;
        end else begin
            case ({capture, pop_ok})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        ent0 <= cap_data;
                    end else begin
                        ent1 <= cap_data;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // The arriving word lands behind whatever survives the pop.
                    if (cnt_q == 2'd2) begin
                        ent0 <= ent1;
                        ent1 <= cap_data;
                    end else begin
                        ent0 <= cap_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (cnt_q != 2'd0);
    assign data  = ent0;
    assign cnt   = cnt_q;

endmodule

// File: rtl/dff_ram_fifo_ctrl.sv
// rtl/dff_ram_fifo_ctrl.sv - valid/ready FIFO built on the single-port dff_ram_8x72
module dff_ram_fifo_ctrl
    import dff_ram_pkg::*;
#(
    parameter int DW   = RAM_DW,
    parameter int AW   = RAM_AW,
    parameter int OBUF = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [3:0]    level,
    output logic          ram_wr_n,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [3:0]    LVL_ONE = 4'd1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_cnt;
    logic          rd_inflight;
    logic [DW-1:0] wdata_q;
    logic [1:0]    obuf_cnt;

    logic          pop_now;
    logic          ram_full;
    logic          ram_empty;
    logic [2:0]    occ_next;
    logic          rd_sel;
    logic          wr_sel;
    ram_op_t       ram_op;

    assign pop_now   = out_valid && out_ready;
    // ram_cnt tops out at exactly 2**AW, so its MSB alone marks full.
    assign ram_full  = ram_cnt[AW];
    assign ram_empty = (ram_cnt == '0);
    assign occ_next  = {1'b0, obuf_cnt} + {2'b0, rd_inflight} - {2'b0, pop_now};

    // Reads win the port so the skid buffer never runs dry while the RAM holds data.
    assign rd_sel   = !ram_empty && (occ_next < 3'(OBUF));
    assign in_ready = rst_n && !rd_sel && !ram_full;
    assign wr_sel   = in_valid && in_ready;

    always_comb begin
        ram_op = RAM_IDLE;
        if (rd_sel) begin
            ram_op = RAM_RD;
        end else if (wr_sel) begin
            ram_op = RAM_WR;
        end
    end

    assign ram_wr_n    = (ram_op != RAM_WR);
    assign ram_address = (ram_op == RAM_WR) ? wr_ptr : rd_ptr;
    assign ram_wdata   = (ram_op == RAM_WR) ? in_data : wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_cnt     <= '0;
            rd_inflight <= 1'b0;
            wdata_q     <= '0;
            level       <= 4'd0;
        end else begin
            case (ram_op)
                RAM_WR: begin
                    wr_ptr  <= wr_ptr + PTR_ONE;
                    ram_cnt <= ram_cnt + CNT_ONE;
                    wdata_q <= in_data;
                end
                RAM_RD: begin
                    rd_ptr  <= rd_ptr + PTR_ONE;
                    ram_cnt <= ram_cnt - CNT_ONE;
                end
                default: ;
            endcase
            rd_inflight <= (ram_op == RAM_RD);
            level       <= level + (wr_sel ? LVL_ONE : 4'd0) - (pop_now ? LVL_ONE : 4'd0);
        end
    end

    fifo_skid_buf2 #(
        .DW(DW)
    ) u_obuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .capture  (rd_inflight),
        .pop      (pop_now),
        .cap_data (ram_rdata),
        .valid    (out_valid),
        .data     (out_data),
        .cnt      (obuf_cnt)
    );

endmodule

// File: tb/tb_dff_ram_fifo_ctrl.sv
// tb/tb_dff_ram_fifo_ctrl.sv - directed bench for dff_ram_fifo_ctrl with the real dff_ram_8x72
module tb_dff_ram_fifo_ctrl;
    import dff_ram_pkg::*;

    localparam int DW = 72;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [3:0]    level;
    logic          ram_wr_n;
    logic [2:0]    ram_address;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dff_ram_fifo_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .ram_wr_n    (ram_wr_n),
        .ram_address (ram_address),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    dff_ram_8x72 u_ram (
        .clk     (clk),
        .wr_n    (ram_wr_n),
        .address (ram_address),
        .wdata   (ram_wdata),
        .rdata   (ram_rdata)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: FIFO contents as a queue, driven only by observed handshakes.
    logic [DW-1:0] model_q[$];
    int            wr_idx = 0;
    int            total_writes = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;

    always @(negedge rst_n) begin
        model_q.delete();
        wr_idx     = 0;
        stall_prev = 1'b0;
    end

    initial begin
        logic          has;
        logic [DW-1:0] head;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("level_model", 72'(level), 72'(model_q.size()));
                chk("level_max", 72'(int'(level) <= FIFO_LEVEL_MAX), 72'd1);
                if (stall_prev) begin
                    chk("stall_valid", 72'(out_valid), 72'd1);
                    chk("stall_data", out_data, stall_data);
                end
                chk("wr_iff_accept", 72'(!ram_wr_n), 72'(in_valid && in_ready));
                if (!ram_wr_n) begin
                    chk("wr_addr", 72'(ram_address), 72'(wr_idx % RAM_DEPTH));
                    chk("wr_data", ram_wdata, in_data);
                    wr_idx++;
                    total_writes++;
                end
                if (out_valid && out_ready) begin
                    has = (model_q.size() > 0);
                    chk("pop_has_entry", 72'(has), 72'd1);
                    if (has) begin
                        head = model_q.pop_front();
                        chk("pop_order", out_data, head);
                    end
                end
                if (in_valid && in_ready) model_q.push_back(in_data);
                stall_prev = out_valid && !out_ready;
                stall_data = out_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d, output bit got);
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic run_stream(input int nwords, input logic [DW-1:0] base, input bit toggle,
                              input int maxcyc, output int pops, output logic [DW-1:0] last);
        int sent;
        sent = 0;
        pops = 0;
        last = '0;
        for (int c = 0; c < maxcyc && pops < nwords; c++) begin
            out_ready = toggle ? (c % 2 == 0) : 1'b1;
            in_valid  = (sent < nwords);
            in_data   = base + 72'(sent);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                pops++;
                last = out_data;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        bit            got;
        int            accepted;
        int            pops;
        int            prev_cyc;
        logic [DW-1:0] last;
        bit            seen;

        // reset state
        #2;
        chk("rst_in_ready", 72'(in_ready), 72'd0);
        chk("rst_out_valid", 72'(out_valid), 72'd0);
        chk("rst_level", 72'(level), 72'd0);
        chk("rst_wr_n", 72'(ram_wr_n), 72'd1);
        chk("rst_addr", 72'(ram_address), 72'd0);
        chk("rst_wdata", ram_wdata, 72'd0);
        #15 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 72'(in_ready), 72'd1);
        chk("post_rst_level", 72'(level), 72'd0);
        tick();

        // fill with consumer stalled
        out_ready = 1'b0;
        accepted  = 0;
        for (int k = 1; k <= 12; k++) begin
            push_word(72'(k), got);
            if (!got) break;
            accepted++;
        end
        chk("fill_accepted", 72'(accepted), 72'd10);
        chk("fill_writes", 72'(wr_idx), 72'd10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fill_level", 72'(level), 72'd10);
            chk("fill_in_ready", 72'(in_ready), 72'd0);
            tick();
        end

        // drain at full rate
        pops     = 0;
        prev_cyc = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 30 && pops < 10; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                chk("drain_value", out_data, 72'(pops + 1));
                if (prev_cyc >= 0) chk("drain_back_to_back", 72'(c), 72'(prev_cyc + 1));
                prev_cyc = c;
                pops++;
            end
            tick();
        end
        chk("drain_pops", 72'(pops), 72'd10);
        @(negedge clk);
        chk("drain_out_valid", 72'(out_valid), 72'd0);
        chk("drain_level", 72'(level), 72'd0);
        tick();

        // single-word latency
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 72'hA5;
        @(negedge clk);
        chk("a5_accept", 72'(in_ready), 72'd1);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i < 3) begin
                chk("a5_not_yet", 72'(out_valid), 72'd0);
            end else begin
                chk("a5_valid", 72'(out_valid), 72'd1);
                chk("a5_data", out_data, 72'hA5);
                chk("a5_level", 72'(level), 72'd1);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("a5_level_after_pop", 72'(level), 72'd0);
        tick();

        // continuous push and pop
        run_stream(20, 72'd1000, 1'b0, 200, pops, last);
        chk("stream_pops", 72'(pops), 72'd20);
        chk("stream_last", last, 72'd1019);
        chk("stream_ptr_wraps", 72'(total_writes >= 3 * RAM_DEPTH), 72'd1);

        // mid-stream asynchronous reset
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_word(72'd200 + 72'(k), got);
            chk("mr_push", 72'(got), 72'd1);
        end
        tick();
        @(posedge clk);
        #1;
        chk("mr_pre_level", 72'(level), 72'd5);
        chk("mr_pre_valid", 72'(out_valid), 72'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_out_valid", 72'(out_valid), 72'd0);
        chk("mr_level", 72'(level), 72'd0);
        chk("mr_wr_n", 72'(ram_wr_n), 72'd1);
        chk("mr_in_ready", 72'(in_ready), 72'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mr_rel_level", 72'(level), 72'd0);
        chk("mr_rel_in_ready", 72'(in_ready), 72'd1);
        tick();
        out_ready = 1'b1;
        push_word(72'd99, got);
        chk("mr_99_accept", 72'(got), 72'd1);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                chk("mr_first_pop", out_data, 72'd99);
            end
            tick();
        end
        chk("mr_first_pop_seen", 72'(seen), 72'd1);
        out_ready = 1'b0;
        tick();

        // backpressure: consumer toggles every cycle
        run_stream(20, 72'd300, 1'b1, 300, pops, last);
        chk("bp_pops", 72'(pops), 72'd20);
        chk("bp_last", last, 72'd319);
        @(negedge clk);
        chk("bp_level", 72'(level), 72'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
